// File: rtl/dm_arb_pkg.sv
// Shared types and constants for the data-memory port arbiter.
//   state_t        : arbiter FSM states (IDLE -> ACCESS -> RESP -> IDLE)
//   ID_A / ID_B    : requester identifiers used for winner tracking
//   lock_cnt_width : width of a counter that must hold 0..lock_max
package dm_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  localparam logic ID_A = 1'b0;
  localparam logic ID_B = 1'b1;

  function automatic int lock_cnt_width(input int lock_max);
    return $clog2(lock_max + 1);
  endfunction

endpackage

// File: rtl/dm_port_arbiter_rr_pick2.sv
// Combinational two-way round-robin picker with bounded lock.
//   req[1:0]    : bit 0 = requester A, bit 1 = requester B
//   last_winner : id of the previous winner
//   lock        : previous winner asks to keep priority
//   lock_cnt    : consecutive locked wins already taken by last_winner
//   gnt[1:0]    : one-hot grant (all zero when nobody requests)
//   win_id      : id of the granted requester (ID_A when idle)
module rr_pick2
  import dm_arb_pkg::*;
#(
  parameter int LOCK_MAX   = 4,
  parameter int LOCK_CNT_W = 3
) (
  input  logic [1:0]            req,
  input  logic                  last_winner,
  input  logic                  lock,
  input  logic [LOCK_CNT_W-1:0] lock_cnt,
  output logic [1:0]            gnt,
  output logic                  win_id
);

  logic keep;

  always_comb begin
    // On a tie the previous winner may stay on top only while its lock
    // budget lasts; otherwise priority flips to the other requester.
    keep   = lock && (lock_cnt < LOCK_CNT_W'(LOCK_MAX));
    win_id = ID_A;
    gnt    = 2'b00;
    case (req)
      2'b01: begin
        win_id = ID_A;
        gnt    = 2'b01;
      end
      2'b10: begin
        win_id = ID_B;
        gnt    = 2'b10;
      end
      2'b11: begin
        win_id = keep ? last_winner : ~last_winner;
        gnt    = (win_id == ID_B) ? 2'b10 : 2'b01;
      end
      default: begin
        win_id = ID_A;
        gnt    = 2'b00;
      end
    endcase
  end

endmodule

// File: rtl/dm_port_arbiter.sv
// Shares the single-port data memory between requester A (MEM stage) and
// requester B (debug/DMA). Round-robin arbitration with a bounded lock;
// one transaction per three cycles (IDLE arbitrates, ACCESS drives the DM,
// RESP returns done/rdata to the winner).
//   clk, reset     : clock; synchronous active-low reset
//   x_req/we/lock  : request, write enable, lock request (x = a, b)
//   x_addr/wdata/pc: byte address, store data, instruction PC
//   x_gnt          : combinational grant, inputs captured at this edge
//   x_done/x_rdata : completion pulse and read data (rdata held between)
//   dm_*           : memory interface, driven only during ACCESS
//   err            : misaligned access dropped (pulses with done)
//   busy           : FSM not in IDLE
module dm_port_arbiter
  import dm_arb_pkg::*;
#(
  parameter int AW       = 32,
  parameter int DW       = 32,
  parameter int LOCK_MAX = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          a_req,
  input  logic          a_we,
  input  logic          a_lock,
  input  logic [AW-1:0] a_addr,
  input  logic [DW-1:0] a_wdata,
  input  logic [31:0]   a_pc,
  output logic          a_gnt,
  output logic          a_done,
  output logic [DW-1:0] a_rdata,
  input  logic          b_req,
  input  logic          b_we,
  input  logic          b_lock,
  input  logic [AW-1:0] b_addr,
  input  logic [DW-1:0] b_wdata,
  input  logic [31:0]   b_pc,
  output logic          b_gnt,
  output logic          b_done,
  output logic [DW-1:0] b_rdata,
  output logic [AW-1:0] dm_addr,
  output logic          dm_we,
  output logic [DW-1:0] dm_wdata,
  output logic [31:0]   dm_pc,
  input  logic [DW-1:0] dm_rdata,
  output logic          err,
  output logic          busy
);

  localparam int LOCK_CNT_W = lock_cnt_width(LOCK_MAX);

  state_t                state, state_nxt;
  logic                  id_q;
  logic                  we_q;
  logic [AW-1:0]         addr_q;
  logic [DW-1:0]         wdata_q;
  logic [31:0]           pc_q;
  logic                  mis_q;
  logic                  last_winner;
  logic [LOCK_CNT_W-1:0] lock_cnt;
  logic [DW-1:0]         a_rdata_q;
  logic [DW-1:0]         b_rdata_q;

  logic [1:0]            pick_gnt;
  logic                  pick_id;
  logic                  prev_lock;
  logic                  win_lock;
  logic                  take;
  logic                  in_access;
  logic                  in_resp;

  // Only the previous winner's lock matters for keeping priority.
  assign prev_lock = (last_winner == ID_B) ? b_lock : a_lock;
  assign win_lock  = (pick_id == ID_B) ? b_lock : a_lock;

  rr_pick2 #(
    .LOCK_MAX  (LOCK_MAX),
    .LOCK_CNT_W(LOCK_CNT_W)
  ) u_pick (
    .req        ({b_req, a_req}),
    .last_winner(last_winner),
    .lock       (prev_lock),
    .lock_cnt   (lock_cnt),
    .gnt        (pick_gnt),
    .win_id     (pick_id)
  );

  // Grants are suppressed while reset is held so nothing is promised that
  // the register stage will not capture.
  assign take  = (state == IDLE) && reset && (|pick_gnt);
  assign a_gnt = take & pick_gnt[0];
  assign b_gnt = take & pick_gnt[1];

  assign mis_q     = |addr_q[1:0];
  assign in_access = (state == ACCESS);
  assign in_resp   = (state == RESP) && reset;

  assign dm_addr  = in_access ? addr_q  : '0;
  assign dm_wdata = in_access ? wdata_q : '0;
  assign dm_pc    = in_access ? pc_q    : '0;
  assign dm_we    = in_access & we_q & ~mis_q & reset;

  assign a_done  = in_resp & (id_q == ID_A);
  assign b_done  = in_resp & (id_q == ID_B);
  assign err     = in_resp & mis_q;
  assign a_rdata = a_rdata_q;
  assign b_rdata = b_rdata_q;
  assign busy    = (state != IDLE);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (take) state_nxt = ACCESS;
      ACCESS:  state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= IDLE;
      id_q        <= ID_A;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      pc_q        <= '0;
      last_winner <= ID_B;
      lock_cnt    <= '0;
      a_rdata_q   <= '0;
      b_rdata_q   <= '0;
    end else begin
      state <= state_nxt;
      // IDLE -> ACCESS: capture the winner's request
      if (take) begin
        id_q        <= pick_id;
        we_q        <= (pick_id == ID_B) ? b_we    : a_we;
        addr_q      <= (pick_id == ID_B) ? b_addr  : a_addr;
        wdata_q     <= (pick_id == ID_B) ? b_wdata : a_wdata;
        pc_q        <= (pick_id == ID_B) ? b_pc    : a_pc;
        last_winner <= pick_id;
        // Only back-to-back locked wins by the same id consume the budget;
        // the counter saturates so it never wraps back into "may keep".
        if ((pick_id == last_winner) && win_lock) begin
          if (lock_cnt != LOCK_CNT_W'(LOCK_MAX))
            lock_cnt <= lock_cnt + LOCK_CNT_W'(1);
        end else begin
          lock_cnt <= '0;
        end
      end
      // ACCESS -> RESP: capture read data for the winner only
      if (state == ACCESS) begin
        if (id_q == ID_B) b_rdata_q <= dm_rdata;
        else              a_rdata_q <= dm_rdata;
      end
    end
  end

endmodule

// File: tb/tb_dm_port_arbiter.sv
// Self-checking bench for dm_port_arbiter: behavioural DM array, a
// cycle model of the arbiter, and a scoreboard of expected completions.
module tb_dm_port_arbiter;

  localparam int AW       = 32;
  localparam int DW       = 32;
  localparam int LOCK_MAX = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          a_req = 1'b0, a_we = 1'b0, a_lock = 1'b0;
  logic [AW-1:0] a_addr = '0;
  logic [DW-1:0] a_wdata = '0;
  logic [31:0]   a_pc = '0;
  logic          a_gnt, a_done;
  logic [DW-1:0] a_rdata;
  logic          b_req = 1'b0, b_we = 1'b0, b_lock = 1'b0;
  logic [AW-1:0] b_addr = '0;
  logic [DW-1:0] b_wdata = '0;
  logic [31:0]   b_pc = '0;
  logic          b_gnt, b_done;
  logic [DW-1:0] b_rdata;
  logic [AW-1:0] dm_addr;
  logic          dm_we;
  logic [DW-1:0] dm_wdata;
  logic [31:0]   dm_pc;
  logic [DW-1:0] dm_rdata;
  logic          err, busy;

  always #5 clk = ~clk;

  dm_port_arbiter #(.AW(AW), .DW(DW), .LOCK_MAX(LOCK_MAX)) dut (
    .clk(clk), .reset(reset),
    .a_req(a_req), .a_we(a_we), .a_lock(a_lock), .a_addr(a_addr),
    .a_wdata(a_wdata), .a_pc(a_pc), .a_gnt(a_gnt), .a_done(a_done),
    .a_rdata(a_rdata),
    .b_req(b_req), .b_we(b_we), .b_lock(b_lock), .b_addr(b_addr),
    .b_wdata(b_wdata), .b_pc(b_pc), .b_gnt(b_gnt), .b_done(b_done),
    .b_rdata(b_rdata),
    .dm_addr(dm_addr), .dm_we(dm_we), .dm_wdata(dm_wdata), .dm_pc(dm_pc),
    .dm_rdata(dm_rdata), .err(err), .busy(busy)
  );

  // Data memory: combinational read, write on posedge.
  logic [31:0] mem [0:63];
  logic        mem_clr = 1'b1;
  assign dm_rdata = mem[dm_addr[7:2]];
  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 64; i++) mem[i] <= '0;
    end else if (dm_we) begin
      mem[dm_addr[7:2]] <= dm_wdata;
    end
  end

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference model and scoreboard
  typedef struct {
    logic        id;
    logic        we;
    logic [31:0] rdata;
    logic        err;
  } exp_t;
  exp_t sb[$];

  localparam int M_IDLE = 0, M_ACC = 1, M_RESP = 2;
  int          m_state = M_IDLE;
  logic        m_last = 1'b1;
  int          m_cnt = 0;
  logic        m_we = 1'b0, m_mis = 1'b0;
  logic [31:0] m_addr = '0, m_wdata = '0, m_pc = '0;
  logic [31:0] ref_mem [0:63];
  logic        mon_en = 1'b0;

  always @(negedge clk) begin
    logic ea, eb, mw, lk, edone;
    exp_t e;
    if (mem_clr) for (int i = 0; i < 64; i++) ref_mem[i] = '0;
    if (mon_en) begin
      ea = 1'b0; eb = 1'b0; mw = 1'b0;
      if (m_state == M_IDLE && reset) begin
        if (a_req && !b_req) ea = 1'b1;
        else if (b_req && !a_req) eb = 1'b1;
        else if (a_req && b_req) begin
          lk = m_last ? b_lock : a_lock;
          mw = (lk && m_cnt < LOCK_MAX) ? m_last : ~m_last;
          ea = ~mw; eb = mw;
        end
      end
      chk("a_gnt", a_gnt, ea);
      chk("b_gnt", b_gnt, eb);
      chk("busy", busy, m_state != M_IDLE);
      chk("dm_we", dm_we, (m_state == M_ACC) && m_we && !m_mis && reset);
      chk("dm_addr", dm_addr, (m_state == M_ACC) ? m_addr : 32'h0);
      chk("dm_wdata", dm_wdata, (m_state == M_ACC) ? m_wdata : 32'h0);
      chk("dm_pc", dm_pc, (m_state == M_ACC) ? m_pc : 32'h0);
      edone = (m_state == M_RESP) && reset;
      chk("done", a_done | b_done, edone);
      chk("err", err, edone && m_mis);
      if (a_done || b_done) begin
        if (sb.size() == 0) chk("sb_underflow", 1, 0);
        else begin
          e = sb.pop_front();
          chk("done_both", a_done & b_done, 0);
          chk("done_id", b_done, e.id);
          chk("done_err", err, e.err);
          if (!e.we && !e.err) chk("rdata", e.id ? b_rdata : a_rdata, e.rdata);
        end
      end
      // advance model to the next cycle
      if (!reset) begin
        m_state = M_IDLE; m_last = 1'b1; m_cnt = 0; sb.delete();
      end else begin
        case (m_state)
          M_IDLE: if (ea || eb) begin
            mw      = eb;
            m_we    = mw ? b_we : a_we;
            m_addr  = mw ? b_addr : a_addr;
            m_wdata = mw ? b_wdata : a_wdata;
            m_pc    = mw ? b_pc : a_pc;
            m_mis   = (m_addr[1:0] != 2'b00);
            lk      = mw ? b_lock : a_lock;
            if (mw == m_last && lk) m_cnt = (m_cnt < LOCK_MAX) ? m_cnt + 1 : m_cnt;
            else m_cnt = 0;
            m_last  = mw;
            e.id = mw; e.we = m_we; e.err = m_mis; e.rdata = ref_mem[m_addr[7:2]];
            sb.push_back(e);
            m_state = M_ACC;
          end
          M_ACC: begin
            if (m_we && !m_mis) ref_mem[m_addr[7:2]] = m_wdata;
            m_state = M_RESP;
          end
          default: m_state = M_IDLE;
        endcase
      end
    end
  end

  logic order[$];

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    tick(); tick();
    reset = 1'b1;
  endtask

  // Hold requests until na A-grants and nb B-grants are seen; record winners.
  task automatic stream(input int na, input int nb, input int max_cyc);
    int   ra, rb;
    logic ga, gb;
    ra = na; rb = nb;
    order.delete();
    a_req = (ra > 0); b_req = (rb > 0);
    for (int i = 0; i < max_cyc && (ra > 0 || rb > 0); i++) begin
      @(negedge clk); ga = a_gnt; gb = b_gnt;
      tick();
      if (ga) begin order.push_back(1'b0); ra--; if (ra == 0) a_req = 1'b0; end
      if (gb) begin order.push_back(1'b1); rb--; if (rb == 0) b_req = 1'b0; end
    end
    chk("stream_timeout", (ra > 0 || rb > 0), 0);
    a_req = 1'b0; b_req = 1'b0;
    repeat (3) tick();
  endtask

  initial begin
    logic exp_ord [0:6];
    // reset held low for two cycles
    tick();
    mon_en = 1'b1;
    tick();
    mem_clr = 1'b0;
    chk("rst_busy", busy, 0);
    chk("rst_a_rdata", a_rdata, 0);
    chk("rst_b_rdata", b_rdata, 0);
    chk("rst_dm_we", dm_we, 0);
    reset = 1'b1;

    // 1: aligned write by A
    a_we = 1'b1; a_addr = 32'h10; a_wdata = 32'h12345678; a_pc = 32'h3000; a_req = 1'b1;
    @(negedge clk); chk("t1_gnt", a_gnt, 1);
    tick(); a_req = 1'b0;
    @(negedge clk);
    chk("t1_dm_we", dm_we, 1);
    chk("t1_dm_addr", dm_addr, 32'h10);
    chk("t1_dm_pc", dm_pc, 32'h3000);
    @(negedge clk); chk("t1_done", a_done, 1);
    tick(); tick();
    chk("t1_mem", mem[4], 32'h12345678);

    // 2: both read from a fresh reset: A, B, A, B
    do_reset();
    a_we = 1'b0; a_addr = 32'h10; a_pc = 32'h3004;
    b_we = 1'b0; b_addr = 32'h20; b_pc = 32'h0BEE;
    stream(2, 2, 40);
    chk("t2_len", order.size(), 4);
    for (int k = 0; k < 4; k++)
      if (k < order.size()) chk($sformatf("t2_win%0d", k), order[k], (k % 2 == 1));

    // 3: B locked stream vs A: four B wins, then A
    b_lock = 1'b1;
    stream(1, 6, 80);
    b_lock = 1'b0;
    exp_ord[0] = 1; exp_ord[1] = 1; exp_ord[2] = 1; exp_ord[3] = 1;
    exp_ord[4] = 0; exp_ord[5] = 1; exp_ord[6] = 1;
    chk("t3_len", order.size(), 7);
    for (int k = 0; k < 7; k++)
      if (k < order.size()) chk($sformatf("t3_win%0d", k), order[k], exp_ord[k]);

    // 4: misaligned write by A is dropped
    a_we = 1'b1; a_addr = 32'h12; a_wdata = 32'hDEADBEEF;
    stream(1, 0, 20);
    chk("t4_mem", mem[4], 32'h12345678);

    // 5: reset during ACCESS of a B write
    b_we = 1'b1; b_addr = 32'h20; b_wdata = 32'hCAFEF00D; b_req = 1'b1;
    @(negedge clk); chk("t5_gnt", b_gnt, 1);
    tick(); b_req = 1'b0; reset = 1'b0;
    @(negedge clk);
    chk("t5_dm_we", dm_we, 0);
    chk("t5_done_acc", b_done, 0);
    tick();
    chk("t5_busy", busy, 0);
    chk("t5_done_nxt", b_done, 0);
    reset = 1'b1;
    @(negedge clk); chk("t5_done_late", b_done, 0);
    chk("t5_mem", mem[8], 32'h0);
    tick();

    // 6: A reads back the word from test 1
    a_we = 1'b0; a_addr = 32'h10;
    stream(1, 0, 20);
    chk("t6_rdata_hold", a_rdata, 32'h12345678);

    chk("sb_drained", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
